// File: rtl/posit_extract_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// posit_defines : default posit geometry, decoded-value struct, width helper
// Rev 1.0
// ---------------------------------------------------------------------------
package posit_defines;

  localparam int DEF_NBITS   = 32;
  localparam int DEF_ES      = 2;
  localparam int DEF_SCALE_W = 8;
  localparam int DEF_FRAC_W  = DEF_NBITS - DEF_ES - 3;

  typedef struct packed {
    logic                          sign;
    logic                          zero;
    logic                          inf;
    logic signed [DEF_SCALE_W-1:0] scale;
    logic [DEF_FRAC_W-1:0]         fraction;
  } posit_dec_t;

  // Width able to hold a regime run length of 1..nbits-1.
  function automatic int posit_cnt_w(input int nbits);
    return $clog2(nbits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_regime_count.sv
`default_nettype none
// ---------------------------------------------------------------------------
// posit_regime_count : regime run length and consumed width of a posit magnitude
// Rev 1.0
// ---------------------------------------------------------------------------
module posit_regime_count import posit_defines::*; #(
  parameter  int NBITS = DEF_NBITS,
  localparam int MW    = posit_cnt_w(NBITS)
) (
  input  logic [NBITS-2:0] abs_i,
  output logic [MW-1:0]    run_o,
  output logic [MW-1:0]    cw_o
);

  logic          run_live;
  logic [MW-1:0] run_cnt;

  always_comb begin
    run_live = 1'b1;
    run_cnt  = '0;
    for (int i = NBITS-2; i >= 0; i--) begin
      if (run_live && (abs_i[i] == abs_i[NBITS-2])) begin
        run_cnt = run_cnt + MW'(1);
      end else begin
        run_live = 1'b0;
      end
    end
  end

  assign run_o = run_cnt;
  // A run that fills the word has no terminating bit to consume.
  assign cw_o  = (run_cnt == MW'(NBITS-1)) ? MW'(NBITS-1) : run_cnt + MW'(1);

endmodule
`default_nettype wire

// File: rtl/posit_extract_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// posit_extract_pipe : 3-stage posit decoder with valid/ready backpressure
// Optional counters: POSIT_EXTRACT_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module posit_extract_pipe import posit_defines::*; #(
  parameter  int NBITS   = DEF_NBITS,
  parameter  int ES      = DEF_ES,
  parameter  int SCALE_W = DEF_SCALE_W,
  localparam int FRAC_W  = NBITS - ES - 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NBITS-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic               out_zero,
  output logic               out_inf,
  output logic [SCALE_W-1:0] out_scale,
  output logic [FRAC_W-1:0]  out_fraction,
  output logic [NBITS-2:0]   out_abs
`ifdef POSIT_EXTRACT_STATS_EN
  ,
  output logic [31:0]        stat_total,
  output logic [31:0]        stat_zero,
  output logic [31:0]        stat_nar
`endif
);

  localparam int MW    = posit_cnt_w(NBITS);
  localparam int REM_W = NBITS - 3;

  if ((2**(SCALE_W-1)) <= ((NBITS-2)*(2**ES) + (2**ES) - 1)) begin : g_scale_w_check
    $error("posit_extract_pipe: SCALE_W too narrow for NBITS/ES");
  end

  logic ld1, ld2, ld3;

  logic             s1_valid_q, s1_sign_q, s1_zero_q, s1_inf_q;
  logic [NBITS-2:0] s1_abs_q, s1_abs_d;

  logic                      s2_valid_q, s2_sign_q, s2_zero_q, s2_inf_q;
  logic [NBITS-2:0]          s2_abs_q;
  logic signed [SCALE_W-1:0] s2_k_q, s2_k_d;
  logic [MW-1:0]             s2_cw_q;

  logic                      s3_valid_q, s3_sign_q, s3_zero_q, s3_inf_q;
  logic [NBITS-2:0]          s3_abs_q;
  logic signed [SCALE_W-1:0] s3_scale_q, s3_scale_d;
  logic [FRAC_W-1:0]         s3_frac_q, s3_frac_d;

  assign ld3      = !s3_valid_q || out_ready;
  assign ld2      = !s2_valid_q || ld3;
  assign ld1      = !s1_valid_q || ld2;
  assign in_ready = ld1;

  assign s1_abs_d = in_data[NBITS-1] ? -in_data[NBITS-2:0] : in_data[NBITS-2:0];

  logic [MW-1:0]             run_len, cons_w;
  logic signed [SCALE_W-1:0] run_ext;

  posit_regime_count #(.NBITS(NBITS)) u_regime (
    .abs_i (s1_abs_q),
    .run_o (run_len),
    .cw_o  (cons_w)
  );

  assign run_ext = SCALE_W'(run_len);
  assign s2_k_d  = s1_abs_q[NBITS-2] ? run_ext - SCALE_W'(1) : -run_ext;

  // At least two regime bits are always consumed, so shift the remainder below them.
  logic [REM_W-1:0]          rem_sh;
  logic signed [SCALE_W-1:0] exp_ext, scale_raw;

  assign rem_sh = s2_abs_q[REM_W-1:0] << (s2_cw_q - MW'(2));

  if (ES > 0) begin : g_exp
    assign exp_ext = SCALE_W'(rem_sh[REM_W-1 -: ES]);
  end else begin : g_no_exp
    assign exp_ext = '0;
  end

  assign scale_raw  = (s2_k_q <<< ES) + exp_ext;
  assign s3_scale_d = (s2_zero_q || s2_inf_q) ? '0 : scale_raw;
  assign s3_frac_d  = (s2_zero_q || s2_inf_q) ? '0 : rem_sh[FRAC_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_zero_q <= 1'b0; s1_inf_q <= 1'b0;
      s1_abs_q   <= '0;
      s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_zero_q <= 1'b0; s2_inf_q <= 1'b0;
      s2_abs_q   <= '0;   s2_k_q    <= '0;   s2_cw_q   <= '0;
      s3_valid_q <= 1'b0; s3_sign_q <= 1'b0; s3_zero_q <= 1'b0; s3_inf_q <= 1'b0;
      s3_abs_q   <= '0;   s3_scale_q <= '0;  s3_frac_q <= '0;
    end else begin
      if (ld1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q <= in_data[NBITS-1];
          s1_zero_q <= (in_data == '0);
          s1_inf_q  <= (in_data == {1'b1, {(NBITS-1){1'b0}}});
          s1_abs_q  <= s1_abs_d;
        end
      end
      if (ld2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sign_q <= s1_sign_q;
          s2_zero_q <= s1_zero_q;
          s2_inf_q  <= s1_inf_q;
          s2_abs_q  <= s1_abs_q;
          s2_k_q    <= s2_k_d;
          s2_cw_q   <= cons_w;
        end
      end
      if (ld3) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_sign_q  <= s2_sign_q;
          s3_zero_q  <= s2_zero_q;
          s3_inf_q   <= s2_inf_q;
          s3_abs_q   <= s2_abs_q;
          s3_scale_q <= s3_scale_d;
          s3_frac_q  <= s3_frac_d;
        end
      end
    end
  end

  assign out_valid    = s3_valid_q;
  assign out_sign     = s3_sign_q;
  assign out_zero     = s3_zero_q;
  assign out_inf      = s3_inf_q;
  assign out_scale    = s3_scale_q;
  assign out_fraction = s3_frac_q;
  assign out_abs      = s3_abs_q;

`ifdef POSIT_EXTRACT_STATS_EN
  logic [31:0] stat_total_q, stat_zero_q, stat_nar_q;
  logic        emit;

  assign emit = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_total_q <= '0;
      stat_zero_q  <= '0;
      stat_nar_q   <= '0;
    end else if (emit) begin
      if (stat_total_q != '1)             stat_total_q <= stat_total_q + 32'd1;
      if (out_zero && stat_zero_q != '1)  stat_zero_q  <= stat_zero_q + 32'd1;
      if (out_inf && stat_nar_q != '1)    stat_nar_q   <= stat_nar_q + 32'd1;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_zero  = stat_zero_q;
  assign stat_nar   = stat_nar_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_posit_extract_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_posit_extract_pipe : directed checks of posit_extract_pipe (32/2 and 16/1)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_posit_extract_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic        a_out_sign, a_out_zero, a_out_inf;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_scale;
  logic [26:0] a_out_fraction;
  logic [30:0] a_out_abs;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_out_sign, b_out_zero, b_out_inf;
  logic [15:0] b_in_data;
  logic [7:0]  b_out_scale;
  logic [11:0] b_out_fraction;
  logic [14:0] b_out_abs;

`ifdef POSIT_EXTRACT_STATS_EN
  logic [31:0] a_stat_total, a_stat_zero, a_stat_nar;
  logic [31:0] b_stat_total, b_stat_zero, b_stat_nar;
`endif

  posit_extract_pipe #(.NBITS(32), .ES(2), .SCALE_W(8)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sign(a_out_sign), .out_zero(a_out_zero), .out_inf(a_out_inf),
    .out_scale(a_out_scale), .out_fraction(a_out_fraction), .out_abs(a_out_abs)
`ifdef POSIT_EXTRACT_STATS_EN
    , .stat_total(a_stat_total), .stat_zero(a_stat_zero), .stat_nar(a_stat_nar)
`endif
  );

  posit_extract_pipe #(.NBITS(16), .ES(1), .SCALE_W(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sign(b_out_sign), .out_zero(b_out_zero), .out_inf(b_out_inf),
    .out_scale(b_out_scale), .out_fraction(b_out_fraction), .out_abs(b_out_abs)
`ifdef POSIT_EXTRACT_STATS_EN
    , .stat_total(b_stat_total), .stat_zero(b_stat_zero), .stat_nar(b_stat_nar)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic [31:0] din, input logic s, input logic z,
                       input logic i, input logic [7:0] sc, input logic [26:0] fr,
                       input logic [30:0] ab);
    @(negedge clk); a_in_data = din; a_in_valid = 1'b1;
    @(negedge clk); a_in_valid = 1'b0; a_in_data = '0;
    @(negedge clk); check({tag, ".early"}, 64'(a_out_valid), 64'd0);
    @(negedge clk); check({tag, ".valid"}, 64'(a_out_valid), 64'd1);
    check({tag, ".sign"},  64'(a_out_sign), 64'(s));
    check({tag, ".zero"},  64'(a_out_zero), 64'(z));
    check({tag, ".inf"},   64'(a_out_inf),  64'(i));
    check({tag, ".scale"}, 64'(a_out_scale), 64'(sc));
    check({tag, ".frac"},  64'(a_out_fraction), 64'(fr));
    check({tag, ".abs"},   64'(a_out_abs), 64'(ab));
  endtask

  task automatic run_b(input string tag, input logic [15:0] din, input logic s, input logic i,
                       input logic [7:0] sc, input logic [11:0] fr, input logic [14:0] ab);
    @(negedge clk); b_in_data = din; b_in_valid = 1'b1;
    @(negedge clk); b_in_valid = 1'b0; b_in_data = '0;
    @(negedge clk); check({tag, ".early"}, 64'(b_out_valid), 64'd0);
    @(negedge clk); check({tag, ".valid"}, 64'(b_out_valid), 64'd1);
    check({tag, ".sign"},  64'(b_out_sign), 64'(s));
    check({tag, ".inf"},   64'(b_out_inf),  64'(i));
    check({tag, ".scale"}, 64'(b_out_scale), 64'(sc));
    check({tag, ".frac"},  64'(b_out_fraction), 64'(fr));
    check({tag, ".abs"},   64'(b_out_abs), 64'(ab));
  endtask

  logic [31:0] sv [5];
  logic [38:0] sx [5];
  logic [15:0] rdy_pat;
  logic [38:0] held;
  logic        was_stall;
  int          ni, no;

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.valid_a", 64'(a_out_valid), 64'd0);
    check("rst.scale_a", 64'(a_out_scale), 64'd0);
    check("rst.abs_a",   64'(a_out_abs),   64'd0);
    check("rst.flags_a", 64'({a_out_sign, a_out_zero, a_out_inf}), 64'd0);
    check("rst.valid_b", 64'(b_out_valid), 64'd0);
`ifdef POSIT_EXTRACT_STATS_EN
    check("rst.stat", 64'({a_stat_total, a_stat_zero}), 64'd0);
`endif
    reset = 1'b0;

    run_a("one",    32'h40000000, 0, 0, 0, 8'h00, 27'h0,       31'h40000000);
    run_a("e1",     32'h48000000, 0, 0, 0, 8'h01, 27'h0,       31'h48000000);
    run_a("neg1",   32'hC0000000, 1, 0, 0, 8'h00, 27'h0,       31'h40000000);
    run_a("minpos", 32'h00000001, 0, 0, 0, 8'h88, 27'h0,       31'h00000001);
    run_a("maxpos", 32'h7FFFFFFF, 0, 0, 0, 8'h78, 27'h0,       31'h7FFFFFFF);
    run_a("zero",   32'h00000000, 0, 1, 0, 8'h00, 27'h0,       31'h00000000);
    run_a("nar",    32'h80000000, 1, 0, 1, 8'h00, 27'h0,       31'h00000000);
    run_a("frac",   32'h4C000000, 0, 0, 0, 8'h01, 27'h4000000, 31'h4C000000);
    run_a("allf",   32'h3FFFFFFF, 0, 0, 0, 8'hFF, 27'h7FFFFFF, 31'h3FFFFFFF);
    run_a("nege2",  32'hB0000000, 1, 0, 0, 8'h02, 27'h0,       31'h50000000);

    run_b("b.one",    16'h4000, 0, 0, 8'h00, 12'h000, 15'h4000);
    run_b("b.minpos", 16'h0001, 0, 0, 8'hE4, 12'h000, 15'h0001);
    run_b("b.maxpos", 16'h7FFF, 0, 0, 8'h1C, 12'h000, 15'h7FFF);
    run_b("b.frac",   16'h5800, 0, 0, 8'h01, 12'h800, 15'h5800);
    run_b("b.nar",    16'h8000, 1, 1, 8'h00, 12'h000, 15'h0000);

    // Backpressured stream: order, no loss, outputs held while stalled.
    sv[0] = 32'h48000000; sx[0] = {8'h01, 31'h48000000};
    sv[1] = 32'h60000000; sx[1] = {8'h04, 31'h60000000};
    sv[2] = 32'h20000000; sx[2] = {8'hFC, 31'h20000000};
    sv[3] = 32'h3FFFFFFF; sx[3] = {8'hFF, 31'h3FFFFFFF};
    sv[4] = 32'hB0000000; sx[4] = {8'h02, 31'h50000000};
    rdy_pat = 16'b1110_0110_1001_0000;
    ni = 0; no = 0; was_stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && no < 5; cyc++) begin
      @(negedge clk);
      if (was_stall) check("stream.hold", 64'({a_out_scale, a_out_abs}), 64'(held));
      a_out_ready = rdy_pat[cyc % 16];
      a_in_valid  = (ni < 5);
      a_in_data   = (ni < 5) ? sv[ni] : 32'h0;
      #1;
      if (a_out_valid && a_out_ready) begin
        check($sformatf("stream.out%0d", no), 64'({a_out_scale, a_out_abs}), 64'(sx[no]));
        no++;
      end
      was_stall = a_out_valid && !a_out_ready;
      held      = {a_out_scale, a_out_abs};
      if (a_in_valid && a_in_ready) ni++;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    check("stream.count", 64'(no), 64'd5);
    repeat (3) @(negedge clk);
    check("stream.nodup", 64'(a_out_valid), 64'd0);

    // Reset with three posits in flight.
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); a_in_valid = 1'b1; a_in_data = 32'h48000000 + 32'(k);
    end
    @(negedge clk); a_in_valid = 1'b0;
    check("flight.full", 64'(a_out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("flight.valid", 64'(a_out_valid), 64'd0);
    check("flight.abs",   64'(a_out_abs),   64'd0);
    reset = 1'b0; a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flight.stale", 64'(a_out_valid), 64'd0);
    end
`ifdef POSIT_EXTRACT_STATS_EN
    check("flight.stat", 64'({a_stat_total, a_stat_nar}), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
